// File: rtl/dm_resp.sv
// dm_resp: wait-stated word memory responder with one-cycle ack and range error
module dm_resp #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic        ack_q, err_q, busy_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [2**ADDR_W];
  logic        idle, go_resp, a_we, in_range, mem_we;
  logic [15:0] a_addr;
  logic [31:0] a_wdata;
  // With zero wait states the access happens on the accept edge, so it uses the live inputs
  always_comb begin
    idle     = state_q == S_IDLE;
    a_we     = idle ? we_i : we_q;
    a_addr   = idle ? addr_i : addr_q;
    a_wdata  = idle ? wdata_i : wdata_q;
    go_resp  = (idle && req_i && WAIT == 0) || (state_q == S_WAIT && cnt_q == 4'd0);
    in_range = (a_addr >> ADDR_W) == 16'd0;
    mem_we   = go_resp && a_we && in_range && !rst;
  end
  // Controller: accept, count wait states, pulse the registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ack_q <= go_resp;
      err_q <= go_resp && !in_range;
      if (go_resp && !in_range) rdata_q <= 32'h0;
      else if (go_resp && !a_we) rdata_q <= mem[a_addr[ADDR_W-1:0]];
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt_q   <= 4'(WAIT - 1);
            state_q <= WAIT == 0 ? S_RESP : S_WAIT;
          end
          busy_q <= req_i;
        end
        S_WAIT: begin
          cnt_q   <= cnt_q - 4'd1;
          state_q <= cnt_q == 4'd0 ? S_RESP : S_WAIT;
          busy_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  // Word array is never reset; a write lands on the edge entering RESP
  always_ff @(posedge clk) begin
    if (mem_we) mem[a_addr[ADDR_W-1:0]] <= a_wdata;
  end
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;
  assign rdata_o = rdata_q;
endmodule

// File: tb/tb_dm_resp.sv
// tb_dm_resp: directed and random transactions on WAIT=2/0/15 instances against a memory model
module tb_dm_resp;
  logic        clk = 0;
  logic        rst = 1;
  logic        req [3];
  logic        we_i = 0;
  logic [15:0] addr_i = 0;
  logic [31:0] wdata_i = 0;
  logic        ack [3];
  logic        err [3];
  logic        busy [3];
  logic [31:0] rdata [3];
  int          wl [3] = '{2, 0, 15};
  logic [31:0] mem_m [3][256];
  bit          known [3][256];
  logic [31:0] rd_m [3];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dm_resp #(.ADDR_W(8), .WAIT(2)) u_w2 (
    .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0]), .busy_o(busy[0]));
  dm_resp #(.ADDR_W(8), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1]), .busy_o(busy[1]));
  dm_resp #(.ADDR_W(8), .WAIT(15)) u_w15 (
    .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ack_o(ack[2]), .rdata_o(rdata[2]), .err_o(err[2]), .busy_o(busy[2]));

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(int i, int n0, output int n);
    n = n0;
    forever begin
      chk("busy_during_txn", busy[i], 1);
      if (ack[i] === 1'b1 || n >= 40) break;
      step();
      n++;
    end
  endtask

  task automatic model(int i, bit w, logic [15:0] a, logic [31:0] d);
    if (a < 16'h100) begin
      if (w) begin
        mem_m[i][a[7:0]] = d;
        known[i][a[7:0]] = 1;
      end else rd_m[i] = mem_m[i][a[7:0]];
    end else rd_m[i] = 32'h0;
  endtask

  task automatic resp_chk(int i, int n, logic [15:0] a);
    chk("latency", n, wl[i] + 1);
    chk("err", err[i], a >= 16'h100);
    chk("rdata", rdata[i], rd_m[i]);
  endtask

  task automatic txn(int i, bit w, logic [15:0] a, logic [31:0] d);
    int n;
    we_i = w; addr_i = a; wdata_i = d; req[i] = 1;
    step();
    req[i] = 0;
    we_i = 1'($urandom); addr_i = 16'($urandom); wdata_i = $urandom;
    wait_ack(i, 1, n);
    model(i, w, a, d);
    resp_chk(i, n, a);
    step();
    chk("ack_one_cycle", ack[i], 0);
    chk("idle_after_resp", busy[i], 0);
  endtask

  initial begin
    int n;
    logic [15:0] a;
    bit w;
    for (int i = 0; i < 3; i++) begin
      req[i] = 0;
      rd_m[i] = 0;
    end
    step();
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ack", ack[i], 0);
      chk("rst_err", err[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_rdata", rdata[i], 0);
    end

    txn(0, 1, 16'h0005, 32'hDEADBEEF);
    txn(0, 0, 16'h0005, 32'h0);
    chk("read_5", rdata[0], 32'hDEADBEEF);

    txn(0, 0, 16'h0100, 32'h0);
    chk("oor_err_rdata", rdata[0], 32'h0);
    txn(0, 1, 16'h0000, 32'h0BADC0DE);
    txn(0, 1, 16'h0100, 32'hFFFFFFFF);
    txn(0, 0, 16'h0000, 32'h0);
    chk("loc0_unchanged", rdata[0], 32'h0BADC0DE);

    we_i = 1; addr_i = 16'h0001; wdata_i = 32'h1; req[0] = 1;
    step();
    we_i = 0; wdata_i = 32'h77777777;
    wait_ack(0, 1, n);
    model(0, 1, 16'h0001, 32'h1);
    resp_chk(0, n, 16'h0001);
    step();
    chk("b2b_idle_gap", busy[0], 0);
    chk("b2b_ack_low", ack[0], 0);
    step();
    chk("b2b_accepted", busy[0], 1);
    req[0] = 0;
    wait_ack(0, 1, n);
    model(0, 0, 16'h0001, 32'h0);
    resp_chk(0, n, 16'h0001);
    chk("b2b_read", rdata[0], 32'h1);
    step();

    txn(0, 1, 16'h0002, 32'h13579BDF);
    we_i = 1; addr_i = 16'h0002; wdata_i = 32'hAAAA5555; req[0] = 1;
    step();
    req[0] = 0;
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) rd_m[i] = 0;
    chk("midrst_busy", busy[0], 0);
    chk("midrst_rdata", rdata[0], 0);
    for (int k = 0; k < 4; k++) begin
      chk("midrst_no_ack", ack[0], 0);
      step();
    end
    txn(0, 0, 16'h0002, 32'h0);
    chk("midrst_prior", rdata[0], 32'h13579BDF);

    txn(0, 1, 16'h0003, 32'h12345678);
    txn(0, 0, 16'h0003, 32'h0);
    chk("scramble_3", rdata[0], 32'h12345678);
    txn(0, 0, 16'h0005, 32'h0);
    chk("scramble_5_untouched", rdata[0], 32'hDEADBEEF);

    txn(1, 1, 16'h00FF, 32'hCAFEF00D);
    txn(1, 0, 16'h00FF, 32'h0);
    chk("w0_read_ff", rdata[1], 32'hCAFEF00D);
    txn(2, 1, 16'h00FF, 32'h5A5AA5A5);
    txn(2, 0, 16'h00FF, 32'h0);
    chk("w15_read_ff", rdata[2], 32'h5A5AA5A5);

    for (int i = 0; i < 3; i++) begin
      repeat (25) begin
        if ($urandom_range(3) == 0) a = 16'h0100 + 16'($urandom_range(16'hFEFF));
        else a = 16'($urandom_range(15));
        w = 1'($urandom_range(1));
        if (!w && a < 16'h100 && !known[i][a[7:0]]) w = 1;
        txn(i, w, a, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_resp.md
# dm_resp

Multi-cycle data-memory responder for the SISC processor: the target side of the processor's load/store request path. It accepts one word-wide read or write request per handshake, models a fixed number of wait states, performs the access against an internal word array, and returns a one-cycle acknowledge carrying read data or an address-range error. It replaces the zero-latency data memory when the core is exercised against slow memory.

## Interface

- ADDR_W, 8, word-address bits actually decoded; depth = 2^ADDR_W 32-bit words
- WAIT, 2, wait-state cycles inserted between accept and acknowledge; legal range 0..15

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  request valid from initiator (level)
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  16  word address; sampled with req
- wdata  in  32  write data; sampled with req
- ack  out  1  one-cycle completion pulse
- rdata  out  32  read data; valid when ack=1 for a read, held until next read completion
- err  out  1  asserted together with ack when the address is out of range
- busy  out  1  1 while a transaction is outstanding (state != IDLE)

## Operation

- States: IDLE, WAIT, RESP. 4-bit down-counter cnt.
- IDLE: if req=1, latch we/addr/wdata into internal registers (accept); go to WAIT with cnt=WAIT-1 if WAIT>0, else directly to RESP. If req=0, stay.
- WAIT: decrement cnt each cycle; when cnt=0, go to RESP.
- Transition into RESP (same edge): perform access using latched values.
  - In range (addr[15:ADDR_W]=0): write -> mem[addr[ADDR_W-1:0]] <= wdata, rdata unchanged; read -> rdata <= mem[addr]. err <= 0.
  - Out of range: no array write; read or write -> rdata <= 0; err <= 1.
- RESP: ack=1 (and err as computed) for exactly one cycle; next state IDLE unconditionally. req ignored in RESP.
- Inputs changing while busy=1 have no effect; only latched values are used.
- Initiator must drop req in the ack cycle unless issuing a new request; req still high in the IDLE cycle following RESP is accepted as a new transaction (latching current addr/we/wdata).
- Memory array is not cleared by rst; unwritten locations read X in simulation. Only controller state and outputs reset.
- Reset (any state, including mid-WAIT): state=IDLE, cnt=0, ack=0, err=0, busy=0, rdata=0; pending access discarded, no array write occurs unless the write edge already passed.

## Timing

- Reset values: ack=0, err=0, busy=0, rdata=32'h0.
- Request accepted at edge ending cycle c (IDLE, req=1). busy=1 in cycles c+1..c+1+WAIT. ack=1 in cycle c+1+WAIT only.
- WAIT=0: ack in cycle c+1. WAIT=2: ack in cycle c+3.
- Minimum spacing between accepts: WAIT+2 cycles (RESP always followed by one IDLE cycle).
- Write visible to a read accepted in the IDLE cycle immediately after RESP.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan

- WAIT=2, ADDR_W=8: write addr=16'h0005 wdata=32'hDEADBEEF, then read addr=16'h0005 -> write ack 3 cycles after accept, err=0; read ack 3 cycles after accept with rdata=32'hDEADBEEF.
- Read addr=16'h0100 (out of range for ADDR_W=8) -> ack with err=1, rdata=0; write to 16'h0100 then read 16'h0000 -> location 0 unchanged.
- Hold req=1 across ack with new addr presented in RESP cycle: write 16'h0001=32'h1 then read 16'h0001 -> two transactions, accepts 4 cycles apart, second returns rdata=32'h00000001.
- Assert rst for one cycle during WAIT of a write to 16'h0002=32'hAAAA5555 -> ack never pulses, busy=0 after reset edge; subsequent read of 16'h0002 returns prior contents (not 32'hAAAA5555).
- Change addr/wdata every cycle while busy=1 during write 16'h0003=32'h12345678 -> read of 16'h0003 returns 32'h12345678; no other location modified.
- Instance with WAIT=0: write then read 16'h00FF=32'hCAFEF00D -> each ack one cycle after accept, rdata=32'hCAFEF00D; WAIT=15 instance -> ack 16 cycles after accept.
